// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Measuring end of a PWM link. Samples an asynchronous PWM input and reports
//   the high time and the period of every complete period in clk cycles. A
//   stuck (DC) input is detected by a timeout.
//
//   Optional duty-fraction divider: define PWM_CAPTURE_DUTY_EN to build it.
//   Without the macro duty_out and duty_valid are tied to 0.
//
// Parameters
//   CNT_W    width of the cycle counter and the measurement outputs
//   TIMEOUT  cycles without an edge before the input is declared DC
//            (must be < 2**CNT_W - 1)
//   DUTY_W   width of the duty result
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   pwm_in      asynchronous PWM input
//   high_out    high time of the last complete period (cycles)
//   period_out  length of the last complete period (cycles)
//   meas_valid  one-cycle pulse when high_out/period_out update
//   timeout     one-cycle pulse when a DC condition is declared
//   dc_level    synchronized input level latched at timeout
//   duty_out    floor(high_out * 2**DUTY_W / period_out)
//   duty_valid  one-cycle pulse when duty_out updates
// -----------------------------------------------------------------------------
module pwm_capture #(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TIMEOUT = 1000000,
   parameter int unsigned DUTY_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_in,
   output logic [CNT_W-1:0]  high_out,
   output logic [CNT_W-1:0]  period_out,
   output logic              meas_valid,
   output logic              timeout,
   output logic              dc_level,
   output logic [DUTY_W-1:0] duty_out,
   output logic              duty_valid
);

   typedef enum logic [1:0] {ARM, HIGH, LOW} state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

   // ---------------------------------------------------------------------
   // Input conditioning: two-stage synchronizer plus one delay stage. Both
   // edges see the same latency, so high time and period are unbiased.
   // ---------------------------------------------------------------------
   logic       sync1_reg;
   logic       s_reg;
   logic       s_d_reg;
   logic [1:0] fill_reg;   // counts clocks since reset until s_d is real data
   logic       rise;
   logic       fall;
   logic       primed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= 1'b0;
         s_reg     <= 1'b0;
         s_d_reg   <= 1'b0;
         fill_reg  <= 2'd0;
      end else begin
         sync1_reg <= pwm_in;
         s_reg     <= sync1_reg;
         s_d_reg   <= s_reg;
         if (fill_reg != 2'd3)
            fill_reg <= fill_reg + 2'd1;
      end
   end

   assign rise   = s_reg & ~s_d_reg;
   assign fall   = ~s_reg & s_d_reg;
   // A rise right after reset may only be the pipeline filling from its zero
   // reset value while pwm_in is already high; arming on it would report a
   // partial period, so ARM ignores rises until the pipeline holds real data.
   assign primed = (fill_reg == 2'd3);

   // ---------------------------------------------------------------------
   // Measurement state machine
   // ---------------------------------------------------------------------
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] h_reg, h_next;
   logic [CNT_W-1:0] high_next, period_next;
   logic             meas_valid_next, timeout_next, dc_level_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ARM;
         cnt_reg    <= '0;
         h_reg      <= '0;
         high_out   <= '0;
         period_out <= '0;
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
         dc_level   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         h_reg      <= h_next;
         high_out   <= high_next;
         period_out <= period_next;
         meas_valid <= meas_valid_next;
         timeout    <= timeout_next;
         dc_level   <= dc_level_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      h_next          = h_reg;
      high_next       = high_out;
      period_next     = period_out;
      meas_valid_next = 1'b0;
      timeout_next    = 1'b0;
      dc_level_next   = dc_level;

      case (state_reg)
         ARM: begin
            cnt_next = '0;
            if (rise && primed) begin
               cnt_next   = ONE;
               state_next = HIGH;
            end
         end
         HIGH: begin
            if (fall) begin
               h_next     = cnt_reg;
               cnt_next   = cnt_reg + ONE;
               state_next = LOW;
            end else if (cnt_reg == TIMEOUT_CNT && !rise) begin
               timeout_next  = 1'b1;
               dc_level_next = s_reg;
               high_next     = '0;
               period_next   = '0;
               cnt_next      = '0;
               state_next    = ARM;
            end else begin
               cnt_next = cnt_reg + ONE;
            end
         end
         LOW: begin
            if (rise) begin
               high_next       = h_reg;
               period_next     = cnt_reg;
               meas_valid_next = 1'b1;
               cnt_next        = ONE;
               state_next      = HIGH;
            end else if (cnt_reg == TIMEOUT_CNT && !fall) begin
               timeout_next  = 1'b1;
               dc_level_next = s_reg;
               high_next     = '0;
               period_next   = '0;
               cnt_next      = '0;
               state_next    = ARM;
            end else begin
               cnt_next = cnt_reg + ONE;
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = ARM;
         end
      endcase
   end

`ifdef PWM_CAPTURE_DUTY_EN
   // ---------------------------------------------------------------------
   // Restoring serial divider: one quotient bit per cycle. Operands are the
   // registered high_out/period_out, which stay put until the next
   // meas_valid or timeout, and both of those abort the division anyway.
   // ---------------------------------------------------------------------
   localparam int unsigned BC_W = $clog2(DUTY_W + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DUTY_W - 1);

   logic              div_busy_reg;
   logic [CNT_W:0]    rem_reg;       // one spare bit for the doubled remainder
   logic [DUTY_W-1:0] quo_reg;
   logic [BC_W-1:0]   bit_cnt_reg;
   logic [CNT_W:0]    rem_sh;
   logic [CNT_W:0]    rem_diff;
   logic              rem_ge;
   logic [DUTY_W-1:0] quo_step;

   assign rem_sh   = rem_reg << 1;
   assign rem_diff = rem_sh - {1'b0, period_out};
   assign rem_ge   = (rem_sh >= {1'b0, period_out});
   assign quo_step = (quo_reg << 1) | DUTY_W'(rem_ge);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_busy_reg <= 1'b0;
         rem_reg      <= '0;
         quo_reg      <= '0;
         bit_cnt_reg  <= '0;
         duty_out     <= '0;
         duty_valid   <= 1'b0;
      end else begin
         duty_valid <= 1'b0;
         if (timeout_next) begin
            // Published together with the timeout pulse.
            div_busy_reg <= 1'b0;
            duty_out     <= {DUTY_W{dc_level_next}};
            duty_valid   <= 1'b1;
         end else if (meas_valid) begin
            // New operands restart the division; a stale result never leaves.
            div_busy_reg <= 1'b1;
            rem_reg      <= {1'b0, high_out};
            quo_reg      <= '0;
            bit_cnt_reg  <= '0;
         end else if (div_busy_reg) begin
            rem_reg     <= rem_ge ? rem_diff : rem_sh;
            quo_reg     <= quo_step;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == LAST_BIT) begin
               div_busy_reg <= 1'b0;
               duty_out     <= quo_step;
               duty_valid   <= 1'b1;
            end
         end
      end
   end
`else
   assign duty_out   = '0;
   assign duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//   Directed bench for pwm_capture with TIMEOUT reduced to 1000. A negedge
//   monitor records every meas_valid / duty_valid pulse; the directed
//   sequence compares recorded and live outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

   localparam int unsigned CNT_W   = 32;
   localparam int unsigned TIMEOUT = 1000;
   localparam int unsigned DUTY_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              pwm_in;
   logic [CNT_W-1:0]  high_out;
   logic [CNT_W-1:0]  period_out;
   logic              meas_valid;
   logic              timeout;
   logic              dc_level;
   logic [DUTY_W-1:0] duty_out;
   logic              duty_valid;

   pwm_capture #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT),
      .DUTY_W  (DUTY_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pwm_in     (pwm_in),
      .high_out   (high_out),
      .period_out (period_out),
      .meas_valid (meas_valid),
      .timeout    (timeout),
      .dc_level   (dc_level),
      .duty_out   (duty_out),
      .duty_valid (duty_valid)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Pulse recorder
   int        cyc       = 0;
   int        mv_count  = 0;
   int        mv_cyc    = 0;
   int        mv_high   = 0;
   int        mv_period = 0;
   int        dv_count  = 0;
   int        dv_gap    = 0;
   int        dv_value  = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (meas_valid === 1'b1) begin
         mv_count  <= mv_count + 1;
         mv_high   <= int'(high_out);
         mv_period <= int'(period_out);
         mv_cyc    <= cyc;
         $display("meas  cyc=%0d high=%0d period=%0d", cyc, high_out, period_out);
      end
      if (duty_valid === 1'b1) begin
         dv_count <= dv_count + 1;
         dv_value <= int'(duty_out);
         dv_gap   <= cyc - mv_cyc;
         $display("duty  cyc=%0d duty=%0d", cyc, duty_out);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // n repetitions of h cycles high followed by l cycles low
   task automatic run(input int h, input int l, input int n);
      for (int i = 0; i < n; i++) begin
         pwm_in = 1'b1;
         repeat (h) @(negedge clk);
         pwm_in = 1'b0;
         repeat (l) @(negedge clk);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   int mv0;
   int dv0;
   int n;

   initial begin
      rst    = 1'b1;
      pwm_in = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_high",    high_out,           0);
      chk("rst_period",  period_out,         0);
      chk("rst_mv",      32'(meas_valid),    0);
      chk("rst_to",      32'(timeout),       0);
      chk("rst_dc",      32'(dc_level),      0);
      chk("rst_duty",    32'(duty_out),      0);
      chk("rst_dv",      32'(duty_valid),    0);

      // 30/70: first report on the second rise
      mv0 = mv_count;
      run(30, 70, 3);
      chk("t1_count",  32'(mv_count - mv0), 2);
      chk("t1_high",   32'(mv_high),        30);
      chk("t1_period", 32'(mv_period),      100);
      chk("t1_hold",   high_out,            30);
`ifdef PWM_CAPTURE_DUTY_EN
      chk("t1_duty",   32'(dv_value),       76);
      chk("t1_gap",    32'(dv_gap),         DUTY_W + 1);
`endif

      // pwm_in high across reset release: the partial period is discarded
      pwm_in = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("t2_rst_period", period_out, 0);
      mv0 = mv_count;
      repeat (50) @(negedge clk);
      pwm_in = 1'b0;
      repeat (80) @(negedge clk);
      chk("t2_partial", 32'(mv_count - mv0), 0);
      run(20, 80, 2);
      chk("t2_count",  32'(mv_count - mv0), 1);
      chk("t2_high",   32'(mv_high),        20);
      chk("t2_period", 32'(mv_period),      100);
`ifdef PWM_CAPTURE_DUTY_EN
      chk("t2_duty",   32'(dv_value),       51);
`endif

      // 10/10 then held high: timeout 1003 cycles after the drive change
      run(10, 10, 3);
      pwm_in = 1'b1;
      n = 0;
      while (timeout !== 1'b1 && n < 1100) begin
         @(negedge clk);
         n++;
      end
      chk("t3_latency",   32'(n),          1003);
      chk("t3_high",      high_out,        0);
      chk("t3_period",    period_out,      0);
      chk("t3_dc",        32'(dc_level),   1);
      chk("t3_last_high", 32'(mv_high),    10);
      chk("t3_last_per",  32'(mv_period),  20);
`ifdef PWM_CAPTURE_DUTY_EN
      chk("t3_duty",      32'(duty_out),   255);
      chk("t3_dv",        32'(duty_valid), 1);
`endif
      @(negedge clk);
      chk("t3_pulse", 32'(timeout), 0);
      mv0 = mv_count;
      repeat (200) @(negedge clk);
      chk("t3_quiet",   32'(mv_count - mv0), 0);
      chk("t3_dc_hold", 32'(dc_level),       1);
      pwm_in = 1'b0;
      repeat (10) @(negedge clk);
      run(10, 10, 2);
      chk("t3_resume",    32'(mv_count - mv0), 1);
      chk("t3_res_high",  32'(mv_high),        10);
      chk("t3_res_per",   32'(mv_period),      20);

      // 1/9: minimum high time
      run(1, 9, 3);
      repeat (10) @(negedge clk);
      chk("t4_high",   32'(mv_high),   1);
      chk("t4_period", 32'(mv_period), 10);
`ifdef PWM_CAPTURE_DUTY_EN
      chk("t4_duty",   32'(dv_value),  25);
      chk("t4_gap",    32'(dv_gap),    DUTY_W + 1);
`endif

      // 2/2: every division is aborted by the next measurement
      mv0 = mv_count;
      dv0 = dv_count;
      run(2, 2, 6);
      chk("t5_count",  32'(mv_count - mv0), 6);
      chk("t5_high",   32'(mv_high),        2);
      chk("t5_period", 32'(mv_period),      4);
      chk("t5_no_dv",  32'(dv_count - dv0), 0);
      repeat (20) @(negedge clk);
`ifdef PWM_CAPTURE_DUTY_EN
      chk("t5_tail_dv",   32'(dv_count - dv0), 1);
      chk("t5_tail_duty", 32'(dv_value),       128);
`else
      chk("t5_duty_off",  32'(duty_out),       0);
`endif

      // 40/60 with reset pulsed inside a HIGH phase
      run(40, 60, 2);
      chk("t6_pre_high", high_out, 40);
      pwm_in = 1'b1;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_high",   high_out,        0);
      chk("t6_period", period_out,      0);
      chk("t6_mv",     32'(meas_valid), 0);
      chk("t6_to",     32'(timeout),    0);
      chk("t6_dc",     32'(dc_level),   0);
      chk("t6_duty",   32'(duty_out),   0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mv0 = mv_count;
      repeat (18) @(negedge clk);
      pwm_in = 1'b0;
      repeat (60) @(negedge clk);
      run(40, 60, 2);
      chk("t6_count",  32'(mv_count - mv0), 1);
      chk("t6_rhigh",  32'(mv_high),        40);
      chk("t6_rper",   32'(mv_period),      100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
